mem_fill_arbiter: RTL and testbench

Shares the single-ported, multi-cycle main memory between the I-cache and D-cache fill FSMs. Grants one requester at a time. For a grant, it either sequences an 8-word (16-byte) block read or a single write-through store. Returned words are steered to the owning cache with a word index, and an end-of-fill pulse is raised so that cache can write its tag array. Sits between both cache fill FSMs and the memory model; its grant signals double as pipeline stall sources.

---
 rtl/mem_fill_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the single-ported main memory between the I-cache and D-cache fill FSMs.
// Sequences 8-word block reads or single write-through stores, steering returned words to the owner.
module mem_fill_arbiter #(
   parameter int WORDS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        i_grant,
   output logic        d_grant,
   output logic [15:0] fill_data,
   output logic [2:0]  fill_word,
   output logic        i_fill_valid,
   output logic        d_fill_valid,
   output logic        i_done,
   output logic        d_done,
   output logic        d_wr_ack,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_data_in,
   input  logic        mem_data_valid
);

   typedef enum logic [2:0] {
      IDLE,
      FILL_ISSUE,
      FILL_DRAIN,
      FILL_DONE,
      STORE
   } state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

   localparam logic [2:0] LAST_WORD = 3'(WORDS - 1);

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   owner_t      last_owner_q, last_owner_d;
   logic [15:0] base_q, base_d;
   logic [2:0]  icnt_q, icnt_d;
   logic [2:0]  rcnt_q, rcnt_d;

   logic win_i, win_d, fill_active, ret;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= OWN_I;
         last_owner_q <= OWN_I;
         base_q       <= '0;
         icnt_q       <= '0;
         rcnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         base_q       <= base_d;
         icnt_q       <= icnt_d;
         rcnt_q       <= rcnt_d;
      end
   end

   // On a tie the requester that did not own memory last time wins.
   assign win_d = d_req && (!i_req || (last_owner_q == OWN_I));
   assign win_i = i_req && (!d_req || (last_owner_q == OWN_D));

   // Returns only count while a fill is in flight; stale returns in IDLE/STORE are dropped.
   assign fill_active = (state_q == FILL_ISSUE) || (state_q == FILL_DRAIN);
   assign ret         = fill_active && mem_data_valid;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      base_d       = base_q;
      icnt_d       = icnt_q;
      rcnt_d       = rcnt_q;

      case (state_q)
         IDLE: begin
            if (win_d) begin
               owner_d      = OWN_D;
               last_owner_d = OWN_D;
               base_d       = d_addr & 16'hFFF0;
               if (d_wr) begin
                  state_d = STORE;
               end else begin
                  state_d = FILL_ISSUE;
                  icnt_d  = '0;
                  rcnt_d  = '0;
               end
            end else if (win_i) begin
               owner_d      = OWN_I;
               last_owner_d = OWN_I;
               base_d       = i_addr & 16'hFFF0;
               state_d      = FILL_ISSUE;
               icnt_d       = '0;
               rcnt_d       = '0;
            end
         end
         FILL_ISSUE: begin
            icnt_d = icnt_q + 3'd1;
            if (icnt_q == LAST_WORD) begin
               state_d = FILL_DRAIN;
            end
         end
         FILL_DRAIN: begin
            state_d = FILL_DRAIN;
         end
         FILL_DONE: begin
            state_d = IDLE;
         end
         STORE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (ret) begin
         rcnt_d = rcnt_q + 3'd1;
         if (rcnt_q == LAST_WORD) begin
            state_d = FILL_DONE;
         end
      end
   end

   always_comb begin
      i_grant      = (state_q != IDLE) && (owner_q == OWN_I);
      d_grant      = (state_q != IDLE) && (owner_q == OWN_D);
      mem_en       = (state_q == FILL_ISSUE) || (state_q == STORE);
      mem_wr       = (state_q == STORE);
      d_wr_ack     = (state_q == STORE);
      i_done       = (state_q == FILL_DONE) && (owner_q == OWN_I);
      d_done       = (state_q == FILL_DONE) && (owner_q == OWN_D);
      i_fill_valid = ret && (owner_q == OWN_I);
      d_fill_valid = ret && (owner_q == OWN_D);
      fill_data    = ret ? mem_data_in : 16'h0000;
      fill_word    = ret ? rcnt_q : 3'd0;
      mem_addr     = 16'h0000;
      mem_wdata    = 16'h0000;
      if (state_q == FILL_ISSUE) begin
         mem_addr = base_q | {12'h000, icnt_q, 1'b0};
      end else if (state_q == STORE) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter: a latency-4 memory, a transaction-level
// model compared every cycle, and directed scenarios with literal expectations.
module tb_mem_fill_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        i_grant, d_grant;
   logic [15:0] fill_data;
   logic [2:0]  fill_word;
   logic        i_fill_valid, d_fill_valid, i_done, d_done, d_wr_ack;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata, mem_data_in;
   logic        mem_data_valid;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_fill_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_req          (i_req),
      .i_addr         (i_addr),
      .d_req          (d_req),
      .d_wr           (d_wr),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .i_grant        (i_grant),
      .d_grant        (d_grant),
      .fill_data      (fill_data),
      .fill_word      (fill_word),
      .i_fill_valid   (i_fill_valid),
      .d_fill_valid   (d_fill_valid),
      .i_done         (i_done),
      .d_done         (d_done),
      .d_wr_ack       (d_wr_ack),
      .mem_en         (mem_en),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_data_in    (mem_data_in),
      .mem_data_valid (mem_data_valid)
   );

   // Memory: each read returns 0xA000 + word index exactly four cycles after issue.
   logic [3:0]  pv = 4'b0000;
   logic [15:0] pd0 = 16'h0, pd1 = 16'h0, pd2 = 16'h0, pd3 = 16'h0;
   logic        spurious = 1'b0;

   always @(posedge clk) begin
      pv  <= {pv[2:0], mem_en && !mem_wr};
      pd0 <= 16'hA000 + {13'h0, mem_addr[3:1]};
      pd1 <= pd0;
      pd2 <= pd1;
      pd3 <= pd2;
   end

   assign mem_data_valid = pv[3] | spurious;
   assign mem_data_in    = spurious ? 16'h5555 : pd3;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr,
                                input logic dw, input logic [15:0] da, input logic [15:0] dwd);
      i_req   = ir;
      i_addr  = ia;
      d_req   = dr;
      d_wr    = dw;
      d_addr  = da;
      d_wdata = dwd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: phase, owner, words issued and words returned.
   localparam int P_IDLE = 0, P_FILL = 1, P_DONE = 2, P_STORE = 3;
   int          m_phase = P_IDLE;
   bit          m_own   = 1'b0;
   bit          m_last  = 1'b0;
   logic [15:0] m_base  = 16'h0;
   int          m_iss   = 0;
   int          m_ret   = 0;

   always @(negedge clk) begin : model_blk
      logic busy, e_men, e_mwr, e_fv;
      busy  = rst_n && (m_phase != P_IDLE);
      e_men = rst_n && ((m_phase == P_FILL && m_iss < 8) || m_phase == P_STORE);
      e_mwr = rst_n && (m_phase == P_STORE);
      e_fv  = rst_n && (m_phase == P_FILL) && mem_data_valid;
      checkOutput("m_i_grant", i_grant, busy && !m_own);
      checkOutput("m_d_grant", d_grant, busy && m_own);
      checkOutput("m_mem_en", mem_en, e_men);
      checkOutput("m_mem_wr", mem_wr, e_mwr);
      checkOutput("m_d_wr_ack", d_wr_ack, e_mwr);
      checkOutput("m_i_done", i_done, rst_n && m_phase == P_DONE && !m_own);
      checkOutput("m_d_done", d_done, rst_n && m_phase == P_DONE && m_own);
      checkOutput("m_i_fill_valid", i_fill_valid, e_fv && !m_own);
      checkOutput("m_d_fill_valid", d_fill_valid, e_fv && m_own);
      if (e_men)
         checkOutput("m_mem_addr", mem_addr,
                     (m_phase == P_STORE) ? d_addr : m_base + 16'(2 * m_iss));
      if (e_mwr)
         checkOutput("m_mem_wdata", mem_wdata, d_wdata);
      if (e_fv) begin
         checkOutput("m_fill_word", {13'h0, fill_word}, 16'(m_ret));
         checkOutput("m_fill_data", fill_data, 16'hA000 + 16'(m_ret));
      end

      if (!rst_n) begin
         m_phase = P_IDLE;
         m_last  = 1'b0;
         m_own   = 1'b0;
         m_iss   = 0;
         m_ret   = 0;
      end else begin
         case (m_phase)
            P_IDLE: begin
               if (i_req || d_req) begin
                  m_own  = !i_req ? 1'b1 : (!d_req ? 1'b0 : !m_last);
                  m_last = m_own;
                  if (m_own && d_wr) begin
                     m_phase = P_STORE;
                  end else begin
                     m_phase = P_FILL;
                     m_base  = (m_own ? d_addr : i_addr) & 16'hFFF0;
                     m_iss   = 0;
                     m_ret   = 0;
                  end
               end
            end
            P_FILL: begin
               if (m_iss < 8) m_iss++;
               if (mem_data_valid) begin
                  if (m_ret == 7) m_phase = P_DONE;
                  else m_ret++;
               end
            end
            default: m_phase = P_IDLE;
         endcase
      end
   end

   task automatic doReset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   // Runs one fill from an idle start and pins its cycle-by-cycle timeline with literals.
   task automatic runFill(input bit is_d, input logic [15:0] addr, input string tag);
      if (is_d) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, addr, 16'h0);
      else      applyStimulus(1'b1, addr, 1'b0, 1'b0, 16'h0, 16'h0);
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 14) begin
            i_req = 1'b0;
            d_req = 1'b0;
         end
         @(negedge clk);
         if (k <= 8)
            checkOutput({tag, "_mem_addr"}, mem_addr, (addr & 16'hFFF0) + 16'(2 * (k - 1)));
         if (k >= 5 && k <= 12) begin
            checkOutput({tag, "_fill_word"}, {13'h0, fill_word}, 16'(k - 5));
            checkOutput({tag, "_fill_data"}, fill_data, 16'hA000 + 16'(k - 5));
            checkOutput({tag, "_fill_valid"}, is_d ? d_fill_valid : i_fill_valid, 1'b1);
         end
         checkOutput({tag, "_done"}, is_d ? d_done : i_done, k == 13);
         checkOutput({tag, "_grant"}, is_d ? d_grant : i_grant, k <= 13);
         checkOutput({tag, "_other_grant"}, is_d ? i_grant : d_grant, 1'b0);
      end
   endtask

   // sel: 0 i_done, 1 d_done, 2 i_grant, 3 d_grant; n = cycles waited, -1 on timeout.
   task automatic waitFor(input int sel, output int n);
      logic hit;
      n = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         @(negedge clk);
         case (sel)
            0:       hit = i_done;
            1:       hit = d_done;
            2:       hit = i_grant;
            default: hit = d_grant;
         endcase
         if (hit) begin
            n = c;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout actual=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int n;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_grant", {14'h0, i_grant, d_grant}, 16'h0);
      checkOutput("reset_mem_en", mem_en, 1'b0);
      tick();

      $display("[TB] basic I fill at 0x1236");
      runFill(1'b0, 16'h1236, "t1");

      $display("[TB] simultaneous requests, round robin");
      doReset();
      applyStimulus(1'b1, 16'h2000, 1'b1, 1'b0, 16'h4000, 16'h0);
      tick();
      @(negedge clk);
      checkOutput("t2_d_first", d_grant, 1'b1);
      checkOutput("t2_i_waits", i_grant, 1'b0);
      waitFor(1, n);
      checkOutput("t2_d_done_cycles", 16'(n), 16'd12);
      waitFor(2, n);
      checkOutput("t2_i_gap", 16'(n), 16'd2);
      waitFor(0, n);
      checkOutput("t2_i_done_cycles", 16'(n), 16'd12);
      waitFor(3, n);
      checkOutput("t2_d_again_gap", 16'(n), 16'd2);
      tick();
      i_req = 1'b0;
      waitFor(1, n);
      checkOutput("t2_d2_done_cycles", 16'(n), 16'd11);
      tick();
      d_req = 1'b0;
      repeat (2) tick();

      $display("[TB] write-through store");
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0101, 16'hBEEF);
      tick();
      @(negedge clk);
      checkOutput("t3_mem_en", mem_en, 1'b1);
      checkOutput("t3_mem_wr", mem_wr, 1'b1);
      checkOutput("t3_mem_addr", mem_addr, 16'h0101);
      checkOutput("t3_mem_wdata", mem_wdata, 16'hBEEF);
      checkOutput("t3_ack", d_wr_ack, 1'b1);
      checkOutput("t3_no_fill", d_fill_valid, 1'b0);
      checkOutput("t3_no_done", d_done, 1'b0);
      tick();
      d_req = 1'b0;
      d_wr  = 1'b0;
      @(negedge clk);
      checkOutput("t3_ack_pulse", d_wr_ack, 1'b0);
      checkOutput("t3_idle_grant", d_grant, 1'b0);
      tick();

      $display("[TB] spurious return while idle");
      spurious = 1'b1;
      @(negedge clk);
      checkOutput("t4_spur_i", i_fill_valid, 1'b0);
      checkOutput("t4_spur_d", d_fill_valid, 1'b0);
      tick();
      spurious = 1'b0;
      runFill(1'b0, 16'h0050, "t4");

      $display("[TB] reset in the middle of an I fill");
      applyStimulus(1'b1, 16'h3000, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (7) tick();
      #1;
      rst_n = 1'b0;
      i_req = 1'b0;
      #1;
      checkOutput("t5_rst_grant", i_grant, 1'b0);
      checkOutput("t5_rst_mem_en", mem_en, 1'b0);
      checkOutput("t5_rst_mem_addr", mem_addr, 16'h0);
      checkOutput("t5_rst_fill_valid", i_fill_valid, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checkOutput("t5_discard", {14'h0, i_fill_valid, d_fill_valid}, 16'h0);
         tick();
      end
      runFill(1'b1, 16'h4000, "t5");

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
